vga_scaled_dbuf_out: RTL

- Parametrised double-buffered frame store at the end of the draw pipeline, in front of the VGA pins.
- Captures the incoming drawn frame into a back bank at reduced resolution (1/SCALE per axis).
- Replays the front bank pixel-replicated, delay-matched to timing, with blank forcing, freeze mode and frame-swap status.
- Storage per bank is (H_ACTIVE/SCALE)*(V_ACTIVE/SCALE) words; this is what makes full-frame buffering fit in BRAM.

---
 rtl/vga_scaled_dbuf_out.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/vga_scaled_dbuf_out.sv
// ---------------------------------------------------------------------------
// vga_scaled_dbuf_out
//
// Double-buffered, reduced-resolution frame store sitting between the draw
// pipeline and the VGA pins.
//
// The drawn frame is decimated by SCALE on each axis and captured into the
// back bank. At the same time the front bank is replayed with each stored pixel
// replicated SCALE x SCALE. The replay is delay-matched so the timing outputs
// stay aligned with the pixel. Banks swap on the last active pixel of a frame
// unless freeze is high at that moment.
//
// Ports
//   clk, rst            pixel clock, synchronous active-high reset
//   in_hcount/vcount    incoming raster position
//   in_hsync/vsync      incoming sync pulses
//   in_hblnk/vblnk      incoming blanking flags
//   in_rgb              pixel from the draw pipeline
//   freeze              1 = keep the current front bank (sampled at frame end)
//   out_*               timing delayed by 2 cycles, displayed pixel
//   frame_done          1-cycle pulse on every bank swap
//   frame_dropped       1-cycle pulse when a frame end is skipped by freeze
// ---------------------------------------------------------------------------
module vga_scaled_dbuf_out #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned SCALE    = 2,
  parameter int unsigned RGB_W    = 12,
  parameter int unsigned CNT_W    = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] in_hcount,
  input  logic [CNT_W-1:0] in_vcount,
  input  logic             in_hsync,
  input  logic             in_vsync,
  input  logic             in_hblnk,
  input  logic             in_vblnk,
  input  logic [RGB_W-1:0] in_rgb,
  input  logic             freeze,
  output logic [CNT_W-1:0] out_hcount,
  output logic [CNT_W-1:0] out_vcount,
  output logic             out_hsync,
  output logic             out_vsync,
  output logic             out_hblnk,
  output logic             out_vblnk,
  output logic [RGB_W-1:0] out_rgb,
  output logic             frame_done,
  output logic             frame_dropped
);

  // Stored image geometry: one word per SCALE x SCALE block of the screen.
  localparam int unsigned H_S   = H_ACTIVE / SCALE;
  localparam int unsigned V_S   = V_ACTIVE / SCALE;
  localparam int unsigned DEPTH = H_S * V_S;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Timing bundle carried through the pipeline next to the pixel.
  typedef struct packed {
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;
  } timing_t;

  // -------------------------------------------------------------------------
  // Address generation
  // -------------------------------------------------------------------------
  logic [31:0]   h_ext;
  logic [31:0]   v_ext;
  logic          pix_active;
  logic          on_grid;
  logic          wr_en;
  logic          frame_end;
  logic [AW-1:0] pix_addr;

  // NOTE: every signal assigned in an always_comb gets a value on every path
  // (here by straight-line assignment) so no latch is inferred.
  always_comb begin
    h_ext      = 32'(in_hcount);
    v_ext      = 32'(in_vcount);
    // The range test keeps an out-of-spec count from indexing past the bank.
    pix_active = !in_hblnk && !in_vblnk && (h_ext < H_ACTIVE) && (v_ext < V_ACTIVE);
    on_grid    = ((h_ext % SCALE) == 32'd0) && ((v_ext % SCALE) == 32'd0);
    wr_en      = pix_active && on_grid;
    frame_end  = pix_active && (h_ext == H_ACTIVE - 1) && (v_ext == V_ACTIVE - 1);
    // Reads use the same formula without the grid test, which is what
    // replicates each stored word across its SCALE x SCALE block. Blanked
    // positions read word 0; the result is masked downstream.
    pix_addr   = pix_active ? AW'((v_ext / SCALE) * H_S + (h_ext / SCALE)) : '0;
  end

  // -------------------------------------------------------------------------
  // Bank control
  // -------------------------------------------------------------------------
  logic bank_sel_q,      bank_sel_d;       // bank currently being written
  logic front_valid_q,   front_valid_d;    // front bank holds a complete frame
  logic frame_done_q,    frame_done_d;
  logic frame_dropped_q, frame_dropped_d;

  // freeze only matters on the frame-end pixel, so a mid-frame change can
  // never move the swap point and tear the image.
  always_comb begin
    bank_sel_d      = bank_sel_q;
    front_valid_d   = front_valid_q;
    frame_done_d    = 1'b0;
    frame_dropped_d = 1'b0;
    if (frame_end) begin
      if (freeze) begin
        frame_dropped_d = 1'b1;
      end else begin
        bank_sel_d    = ~bank_sel_q;
        front_valid_d = 1'b1;
        frame_done_d  = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_sel_q      <= 1'b0;
      front_valid_q   <= 1'b0;
      frame_done_q    <= 1'b0;
      frame_dropped_q <= 1'b0;
    end else begin
      bank_sel_q      <= bank_sel_d;
      front_valid_q   <= front_valid_d;
      frame_done_q    <= frame_done_d;
      frame_dropped_q <= frame_dropped_d;
    end
  end

  // -------------------------------------------------------------------------
  // Pipeline: stage 1 registers read address + timing, stage 2 is the RAM read
  // -------------------------------------------------------------------------
  timing_t       in_tim;
  timing_t       s1_tim_q;
  timing_t       s2_tim_q;
  logic          s1_bank_q;
  logic [AW-1:0] s1_addr_q;
  logic          s1_valid_q;
  logic          s2_valid_q;

  assign in_tim = {in_hcount, in_vcount, in_hsync, in_vsync, in_hblnk, in_vblnk};

  // The front bank and its valid flag are captured together with the address,
  // so a swap on the frame-end pixel cannot affect reads already in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_tim_q   <= '0;
      s1_bank_q  <= 1'b0;
      s1_addr_q  <= '0;
      s1_valid_q <= 1'b0;
      s2_tim_q   <= '0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_tim_q   <= in_tim;
      s1_bank_q  <= ~bank_sel_q;
      s1_addr_q  <= pix_addr;
      s1_valid_q <= front_valid_q;
      s2_tim_q   <= s1_tim_q;
      s2_valid_q <= s1_valid_q;
    end
  end

  // -------------------------------------------------------------------------
  // Frame store: two banks, one write port and one read port.
  // Writes go to bank_sel, reads to the other bank. The only cycle where a read
  // sees the new bank assignment is just after the frame-end pixel, and that
  // position is horizontal blanking, so no write is pending there.
  // -------------------------------------------------------------------------
  logic [RGB_W-1:0] mem_q [2][DEPTH];
  logic [RGB_W-1:0] rd_data_q;

  // NOTE: the storage array and its read register are deliberately left out of
  // reset; a reset port on them would prevent mapping onto block RAM, and
  // stale contents are hidden by front_valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[bank_sel_q][pix_addr] <= in_rgb;
    end
    rd_data_q <= mem_q[s1_bank_q][s1_addr_q];
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign out_hcount    = s2_tim_q.hcount;
  assign out_vcount    = s2_tim_q.vcount;
  assign out_hsync     = s2_tim_q.hsync;
  assign out_vsync     = s2_tim_q.vsync;
  assign out_hblnk     = s2_tim_q.hblnk;
  assign out_vblnk     = s2_tim_q.vblnk;
  // Blanking and an empty front bank both force black. The reset-cleared
  // valid flag also covers the unreset RAM read register.
  assign out_rgb       = (s2_tim_q.hblnk || s2_tim_q.vblnk || !s2_valid_q) ? '0 : rd_data_q;
  assign frame_done    = frame_done_q;
  assign frame_dropped = frame_dropped_q;

endmodule
